// File: rtl/rsa_decryptor_if.sv
// Operand/result bundle for rsa_decryptor.
// The master side issues requests and the slave side (the decryptor) returns results.
interface rsa_decryptor_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] cipher_val;
    logic [WIDTH-1:0] private_key;
    logic [WIDTH-1:0] modulus_key;
    logic             busy;
    logic             cal_done;
    logic             err;
    logic [WIDTH-1:0] msg_val;

    modport master (
        output start, cipher_val, private_key, modulus_key,
        input  busy, cal_done, err, msg_val
    );

    modport slave (
        input  start, cipher_val, private_key, modulus_key,
        output busy, cal_done, err, msg_val
    );
endinterface

// File: rtl/rsa_decryptor.sv
// RSA decryptor: m = c^d mod n.
// Uses left-to-right square-and-multiply. The modular multiplier is a bit-serial
// Blakley interleaved unit that takes WIDTH cycles per product.
// Optional macro RSA_CONST_TIME_EN: run MUL for every exponent bit and commit the
// product only when the bit is set. This gives a fixed, data-independent latency.
module rsa_decryptor #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    rsa_decryptor_if.slave   bus
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, CHECK, SQR, MUL, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] c_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] n_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] msg_reg;
    logic             err_reg;
    logic [IW-1:0]    exp_idx;
    logic [IW-1:0]    bit_idx;

    logic [WIDTH-1:0] mul_y;
    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   dbl_red;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sum_red;
    logic [WIDTH-1:0] acc_next;
    logic             operand_bad;
    logic             mul_last;
    logic             exp_bit;
    logic             exp_last;
    logic             commit;

    // One Blakley step: double the accumulator, reduce, conditionally add R, reduce again.
    always_comb begin
        mul_y       = (state == MUL) ? c_reg : r_reg;
        dbl         = {acc, 1'b0};
        dbl_red     = (dbl >= {1'b0, n_reg}) ? dbl - {1'b0, n_reg} : dbl;
        sum         = dbl_red + (mul_y[bit_idx] ? {1'b0, r_reg} : {(WIDTH+1){1'b0}});
        sum_red     = (sum >= {1'b0, n_reg}) ? sum - {1'b0, n_reg} : sum;
        acc_next    = sum_red[WIDTH-1:0];
        operand_bad = (n_reg < WIDTH'(2)) || (c_reg >= n_reg);
        mul_last    = (bit_idx == '0);
        exp_bit     = d_reg[exp_idx];
        exp_last    = (exp_idx == '0);
        commit      = (state == SQR) || exp_bit;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state selection over the exponent scan.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (bus.start) state_next = CHECK;
            CHECK: state_next = operand_bad ? DONE : SQR;
            SQR: begin
                if (mul_last) begin
`ifdef RSA_CONST_TIME_EN
                    state_next = MUL;
`else
                    if (exp_bit)       state_next = MUL;
                    else if (exp_last) state_next = DONE;
                    else               state_next = SQR;
`endif
                end
            end
            MUL:   if (mul_last) state_next = exp_last ? DONE : SQR;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the state; results come from held registers.
    always_comb begin
        bus.busy     = (state != IDLE);
        bus.cal_done = (state == DONE);
        bus.err      = err_reg;
        bus.msg_val  = msg_reg;
    end

    // Datapath: latch operands, check them, then run multiply iterations and exponent-bit updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_reg   <= '0;
            d_reg   <= '0;
            n_reg   <= '0;
            r_reg   <= '0;
            acc     <= '0;
            msg_reg <= '0;
            err_reg <= 1'b0;
            exp_idx <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        c_reg   <= bus.cipher_val;
                        d_reg   <= bus.private_key;
                        n_reg   <= bus.modulus_key;
                        err_reg <= 1'b0;
                        msg_reg <= '0;
                    end
                end
                CHECK: begin
                    if (operand_bad) begin
                        err_reg <= 1'b1;
                        msg_reg <= '0;
                    end else begin
                        r_reg   <= WIDTH'(1);
                        acc     <= '0;
                        exp_idx <= LAST_IDX;
                        bit_idx <= LAST_IDX;
                    end
                end
                SQR, MUL: begin
                    if (mul_last) begin
                        acc     <= '0;
                        bit_idx <= LAST_IDX;
                        if (commit) r_reg <= acc_next;
                        if (state_next == DONE) msg_reg <= commit ? acc_next : r_reg;
                        if (state == MUL || state_next == SQR) exp_idx <= exp_idx - 1'b1;
                    end else begin
                        acc     <= acc_next;
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_decryptor.sv
// Scoreboard testbench for rsa_decryptor (WIDTH=64).
// Stimulus pushes expected results into a queue; a negedge monitor checks each cal_done.
module tb_rsa_decryptor;
    localparam int W = 64;

    typedef struct {
        logic [W-1:0] msg;
        logic         err;
        int           lat;
    } exp_t;

    typedef struct {
        logic [W-1:0] c;
        logic [W-1:0] d;
        logic [W-1:0] n;
        logic [W-1:0] m;
        int           pop;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    rsa_decryptor_if #(.WIDTH(W)) bus ();

    rsa_decryptor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   accept_cyc = 0;
    int   done_count = 0;
    int   total = 0;
    int   bad = 0;
    bit   in_flight = 0;
    bit   busy_gap = 0;
    bit   after_done = 0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int expLatency(input int pop);
`ifdef RSA_CONST_TIME_EN
        return 1 + 2 * W * W;
`else
        return 1 + W * W + pop * W;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: compare every completion against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (after_done) begin
                checkOutput("cal_done_one_cycle", {63'd0, bus.cal_done}, 64'd0);
                checkOutput("busy_after_done", {63'd0, bus.busy}, 64'd0);
                after_done = 0;
            end else if (bus.cal_done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_cal_done: got 1 expected 0");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("msg_val", bus.msg_val, e.msg);
                    checkOutput("err", {63'd0, bus.err}, {63'd0, e.err});
                    checkOutput("latency", 64'(cyc - accept_cyc), 64'(e.lat));
                    checkOutput("busy_window", {63'd0, bus.busy && !busy_gap}, 64'd1);
                end
                in_flight = 0;
                after_done = 1;
                done_count++;
            end else if (in_flight && !bus.busy) begin
                busy_gap = 1;
            end
        end
    end

    task automatic waitDone(input int target, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_count >= target) break;
        end
        if (done_count < target) begin
            total++;
            bad++;
            $display("[TB] FAIL done_timeout: got no cal_done expected one within %0d cycles", budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic acceptOp(input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] n);
        @(negedge clk);
        bus.cipher_val  = c;
        bus.private_key = d;
        bus.modulus_key = n;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        busy_gap   = 0;
        in_flight  = 1;
    endtask

    task automatic applyStimulus(input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] n,
                                 input logic [W-1:0] m, input logic e, input int lat);
        int target;
        target = done_count + 1;
        acceptOp(c, d, n);
        bus.start       = 1'b0;
        bus.cipher_val  = '1;
        bus.private_key = '1;
        bus.modulus_key = '0;
        exp_q.push_back('{msg: m, err: e, lat: lat});
        waitDone(target, lat + 50);
    endtask

    vec_t vecs[6];

    initial begin
        int target;
        bus.start       = 1'b0;
        bus.cipher_val  = '0;
        bus.private_key = '0;
        bus.modulus_key = '0;

        vecs[0] = '{c: 64'd2790, d: 64'd2753, n: 64'd3233, m: 64'd65,  pop: 5};
        vecs[1] = '{c: 64'd855,  d: 64'd2753, n: 64'd3233, m: 64'd123, pop: 5};
        vecs[2] = '{c: 64'd5,    d: 64'd0,    n: 64'd3233, m: 64'd1,   pop: 0};
        vecs[3] = '{c: 64'd0,    d: 64'd2753, n: 64'd3233, m: 64'd0,   pop: 5};
        vecs[4] = '{c: 64'd2,    d: 64'd10,   n: 64'd1000, m: 64'd24,  pop: 2};
        vecs[5] = '{c: 64'hFFFF_FFFF_FFFF_FFFE, d: 64'd255, n: 64'hFFFF_FFFF_FFFF_FFFF,
                    m: 64'hFFFF_FFFF_FFFF_FFFE, pop: 8};

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("reset_cal_done", {63'd0, bus.cal_done}, 64'd0);
        checkOutput("reset_err", {63'd0, bus.err}, 64'd0);
        checkOutput("reset_msg_val", bus.msg_val, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            applyStimulus(vecs[i].c, vecs[i].d, vecs[i].n, vecs[i].m, 1'b0, expLatency(vecs[i].pop));

        // Operand errors.
        applyStimulus(64'd3233, 64'd2753, 64'd3233, 64'd0, 1'b1, 1);
        applyStimulus(64'd5, 64'd2753, 64'd1, 64'd0, 1'b1, 1);

        // n=0 error, plus a start pulse in the DONE cycle that must be ignored.
        target = done_count + 1;
        acceptOp(64'd5, 64'd2753, 64'd0);
        bus.start = 1'b0;
        exp_q.push_back('{msg: 64'd0, err: 1'b1, lat: 1});
        for (int k = 0; k < 10 && !bus.cal_done; k++) @(negedge clk);
        bus.cipher_val  = 64'd2790;
        bus.private_key = 64'd2753;
        bus.modulus_key = 64'd3233;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitDone(target, 20);

        // start held high and pulsed mid-operation with other operands.
        target = done_count + 1;
        acceptOp(64'd2790, 64'd2753, 64'd3233);
        exp_q.push_back('{msg: 64'd65, err: 1'b0, lat: expLatency(5)});
        bus.cipher_val  = 64'd5;
        bus.private_key = 64'd3;
        bus.modulus_key = 64'd7;
        repeat (500) @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.start       = 1'b1;
        bus.cipher_val  = 64'd9;
        bus.private_key = 64'd4;
        bus.modulus_key = 64'd11;
        repeat (2000) @(posedge clk);
        #1 bus.start = 1'b0;
        waitDone(target, expLatency(5) + 50);

        // Reset mid-operation.
        acceptOp(64'd2790, 64'd2753, 64'd3233);
        bus.start = 1'b0;
        repeat (999) @(posedge clk);
        #1;
        rst       = 1'b1;
        in_flight = 0;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("abort_cal_done", {63'd0, bus.cal_done}, 64'd0);
        checkOutput("abort_err", {63'd0, bus.err}, 64'd0);
        checkOutput("abort_msg_val", bus.msg_val, 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        applyStimulus(64'd2790, 64'd2753, 64'd3233, 64'd65, 1'b0, expLatency(5));

        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
